muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sequencer: 32-bit iterative MULT/MULTU/DIV/DIVU unit with HI/LO.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_Start,
  input  logic [1:0]  id_MulDivOp,
  input  logic [31:0] id_OpA,
  input  logic [31:0] id_OpB,
  input  logic        id_MtHi,
  input  logic        id_MtLo,
  input  logic        id_MfHi,
  input  logic        id_MfLo,
  input  logic        id_Flush,
  output logic        ex_Stall,
  output logic        ex_Busy,
  output logic        ex_Done,
  output logic        ex_DivZero,
  output logic [31:0] ex_HiOut,
  output logic [31:0] ex_LoOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] work_hi_q, work_hi_d;
  logic [31:0] work_lo_q, work_lo_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        divz_q, divz_d;

  logic        is_div;
  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign abs_a     = (is_signed && opa_q[31]) ? (~opa_q + 32'd1) : opa_q;
  assign abs_b     = (is_signed && opb_q[31]) ? (~opb_q + 32'd1) : opb_q;

  // Restoring divide: partial remainder in work_hi, dividend/quotient shifts through work_lo.
  assign rem_shift = {work_hi_q, work_lo_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, opb_q});
  assign rem_sub   = rem_shift[31:0] - opb_q;

  // Shift-add multiply: multiplier bits consumed from work_lo[0], product grows into work_hi.
  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : 33'd0);

  assign prod_fix  = neg_q ? (~{work_hi_q, work_lo_q} + 64'd1) : {work_hi_q, work_lo_q};
  assign quo_fix   = neg_q ? (~work_lo_q + 32'd1) : work_lo_q;
  assign rem_fix   = neg_rem_q ? (~work_hi_q + 32'd1) : work_hi_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (id_Start) begin
          state_d = S_PREP;
          op_d    = id_MulDivOp;
          opa_d   = id_OpA;
          opb_d   = id_OpB;
        end else begin
          if (id_MtHi) hi_d = id_OpA;
          if (id_MtLo) lo_d = id_OpA;
        end
      end
      S_PREP: begin
        if (is_div && (opb_q == 32'd0)) begin
          state_d = S_IDLE;
          divz_d  = 1'b1;
        end else begin
          state_d   = S_RUN;
          count_d   = 6'd0;
          work_hi_d = 32'd0;
          work_lo_d = abs_a;
          opb_d     = abs_b;
          neg_d     = is_signed && (opa_q[31] ^ opb_q[31]);
          neg_rem_d = is_signed && opa_q[31];
        end
      end
      S_RUN: begin
        if (is_div) begin
          work_hi_d = rem_ge ? rem_sub : rem_shift[31:0];
          work_lo_d = {work_lo_q[30:0], rem_ge};
        end else begin
          work_hi_d = mul_sum[32:1];
          work_lo_d = {mul_sum[0], work_lo_q[31:1]};
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything except reset and never touches HI/LO.
    if (id_Flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      divz_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= 6'd0;
      op_q      <= 2'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
    end
  end

  assign ex_Busy    = (state_q != S_IDLE);
  assign ex_Stall   = ex_Busy && (id_Start || id_MfHi || id_MfLo || id_MtHi || id_MtLo);
  assign ex_Done    = done_q;
  assign ex_DivZero = divz_q;
  assign ex_HiOut   = hi_q;
  assign ex_LoOut   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_sequencer: directed vector bench for muldiv_sequencer.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        id_Start;
  logic [1:0]  id_MulDivOp;
  logic [31:0] id_OpA;
  logic [31:0] id_OpB;
  logic        id_MtHi;
  logic        id_MtLo;
  logic        id_MfHi;
  logic        id_MfLo;
  logic        id_Flush;
  logic        ex_Stall;
  logic        ex_Busy;
  logic        ex_Done;
  logic        ex_DivZero;
  logic [31:0] ex_HiOut;
  logic [31:0] ex_LoOut;

  int checks;
  int errors;

  muldiv_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .id_Start    (id_Start),
    .id_MulDivOp (id_MulDivOp),
    .id_OpA      (id_OpA),
    .id_OpB      (id_OpB),
    .id_MtHi     (id_MtHi),
    .id_MtLo     (id_MtLo),
    .id_MfHi     (id_MfHi),
    .id_MfLo     (id_MfLo),
    .id_Flush    (id_Flush),
    .ex_Stall    (ex_Stall),
    .ex_Busy     (ex_Busy),
    .ex_Done     (ex_Done),
    .ex_DivZero  (ex_DivZero),
    .ex_HiOut    (ex_HiOut),
    .ex_LoOut    (ex_LoOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for ex_Done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nb, output logic done_one);
    id_Start    = 1'b1;
    id_MulDivOp = op;
    id_OpA      = a;
    id_OpB      = b;
    tick();
    id_Start    = 1'b0;
    id_OpA      = ~a;
    id_OpB      = b ^ 32'h5;
    id_MulDivOp = ~op;
    lat = 0;
    nb  = 0;
    while (!ex_Done && lat < 100) begin
      if (ex_Busy) nb++;
      tick();
      lat++;
    end
    tick();
    done_one = !ex_Done;
  endtask

  int   lat;
  int   nb;
  int   cnt;
  logic done_one;
  logic seen_done;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; id_Start = 1'b0; id_MulDivOp = 2'b00; id_OpA = 32'd0; id_OpB = 32'd0;
    id_MtHi = 1'b0; id_MtLo = 1'b0; id_MfHi = 1'b0; id_MfLo = 1'b0; id_Flush = 1'b0;

    vecs[0]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[11] = '{2'b11, 32'd5,        32'd10,       32'd5,        32'd0};

    repeat (3) tick();
    reset = 1'b1;
    chk("rst_busy", ex_Busy, 0);
    chk("rst_stall", ex_Stall, 0);
    chk("rst_hi", ex_HiOut, 0);
    chk("rst_lo", ex_LoOut, 0);
    chk("rst_done", ex_Done, 0);
    chk("rst_divzero", ex_DivZero, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb, done_one);
      chk($sformatf("v%0d_latency", i), lat, 34);
      chk($sformatf("v%0d_busy_cycles", i), nb, 34);
      chk($sformatf("v%0d_hi", i), ex_HiOut, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), ex_LoOut, vecs[i].exp_lo);
      chk($sformatf("v%0d_done_width", i), done_one, 1);
    end

    // Moves, then divide by zero leaves HI/LO alone.
    id_MtHi = 1'b1; id_OpA = 32'h11; tick(); id_MtHi = 1'b0;
    id_MtLo = 1'b1; id_OpA = 32'h22; tick(); id_MtLo = 1'b0;
    chk("mt_hi", ex_HiOut, 32'h11);
    chk("mt_lo", ex_LoOut, 32'h22);
    id_Start = 1'b1; id_MulDivOp = 2'b10; id_OpA = 32'd5; id_OpB = 32'd0;
    tick();
    id_Start = 1'b0;
    chk("dz_prep_busy", ex_Busy, 1);
    tick();
    chk("dz_busy", ex_Busy, 0);
    chk("dz_pulse", ex_DivZero, 1);
    chk("dz_done", ex_Done, 0);
    chk("dz_hi", ex_HiOut, 32'h11);
    chk("dz_lo", ex_LoOut, 32'h22);
    tick();
    chk("dz_pulse_end", ex_DivZero, 0);

    // Start beats a simultaneous move; MfLo held stalls for the whole operation.
    id_Start = 1'b1; id_MtHi = 1'b1; id_MulDivOp = 2'b01; id_OpA = 32'd3; id_OpB = 32'd4;
    tick();
    id_Start = 1'b0; id_MtHi = 1'b0; id_MfLo = 1'b1;
    chk("mt_ignored_hi", ex_HiOut, 32'h11);
    cnt = 0;
    lat = 0;
    while (!ex_Done && lat < 100) begin
      if (ex_Stall) cnt++;
      tick();
      lat++;
    end
    chk("stall_cycles", cnt, 34);
    chk("stall_done_cycle", ex_Stall, 0);
    chk("stall_new_lo", ex_LoOut, 32'd12);
    id_MfLo = 1'b0;
    tick();

    // Reset at RUN count 10.
    id_Start = 1'b1; id_MulDivOp = 2'b00; id_OpA = 32'd9; id_OpB = 32'd9;
    tick();
    id_Start = 1'b0;
    repeat (11) tick();
    chk("rst_mid_busy_before", ex_Busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_mid_busy", ex_Busy, 0);
    chk("rst_mid_hi", ex_HiOut, 0);
    chk("rst_mid_lo", ex_LoOut, 0);
    run_op(2'b01, 32'd3, 32'd4, lat, nb, done_one);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_hi", ex_HiOut, 0);
    chk("post_rst_lo", ex_LoOut, 32'd12);

    // Flush at RUN count 20 with a competing start.
    id_MtHi = 1'b1; id_MtLo = 1'b1; id_OpA = 32'hAA; tick(); id_MtHi = 1'b0; id_MtLo = 1'b0;
    id_Start = 1'b1; id_MulDivOp = 2'b01; id_OpA = 32'd5; id_OpB = 32'd6;
    tick();
    id_Start = 1'b0;
    repeat (21) tick();
    id_Flush = 1'b1; id_Start = 1'b1;
    tick();
    id_Flush = 1'b0; id_Start = 1'b0;
    chk("flush_busy", ex_Busy, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ex_Done || ex_Busy) seen_done = 1'b1;
      tick();
    end
    chk("flush_no_done", seen_done, 0);
    chk("flush_hi", ex_HiOut, 32'hAA);
    chk("flush_lo", ex_LoOut, 32'hAA);

    // Flush in FIX suppresses the write.
    id_Start = 1'b1; id_MulDivOp = 2'b01; id_OpA = 32'd5; id_OpB = 32'd6;
    tick();
    id_Start = 1'b0;
    repeat (33) tick();
    chk("fix_busy", ex_Busy, 1);
    id_Flush = 1'b1;
    tick();
    id_Flush = 1'b0;
    chk("fix_flush_done", ex_Done, 0);
    chk("fix_flush_busy", ex_Busy, 0);
    chk("fix_flush_lo", ex_LoOut, 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
